// File: rtl/gamepad_pmod_pkg.sv
// Shared constants for the Gamepad Pmod receiver: per-pad button bit positions and
// the pattern an unplugged controller shifts out.
package gamepad_pmod_pkg;

  localparam int unsigned BITS_PER_PAD = 12;
  localparam logic [BITS_PER_PAD-1:0] ABSENT_PATTERN = 12'hFFF;

  localparam int unsigned BTN_B     = 11;
  localparam int unsigned BTN_Y     = 10;
  localparam int unsigned BTN_SEL   = 9;
  localparam int unsigned BTN_START = 8;
  localparam int unsigned BTN_UP    = 7;
  localparam int unsigned BTN_DOWN  = 6;
  localparam int unsigned BTN_LEFT  = 5;
  localparam int unsigned BTN_RIGHT = 4;
  localparam int unsigned BTN_A     = 3;
  localparam int unsigned BTN_X     = 2;
  localparam int unsigned BTN_L     = 1;
  localparam int unsigned BTN_R     = 0;

  // Unplugged pads float high, so an all-ones slot means nothing is attached.
  function automatic logic pad_present(input logic [BITS_PER_PAD-1:0] i_bits);
    return i_bits != ABSENT_PATTERN;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchronizer for an asynchronous pin, plus a one-cycle rising-edge pulse
// derived from one extra flop behind the synchronized level.
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/gamepad_pmod_rx.sv
// Gamepad Pmod serial receiver: shifts in data/clk/latch frames, validates the bit count,
// and presents per-pad button state and presence with a no-frame timeout.
module gamepad_pmod_rx
  import gamepad_pmod_pkg::*;
#(
  parameter int unsigned NUM_PADS       = 2,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             pmod_data,
  input  logic                             pmod_clk,
  input  logic                             pmod_latch,
  output logic [BITS_PER_PAD*NUM_PADS-1:0] buttons,
  output logic [NUM_PADS-1:0]              is_present,
  output logic                             frame_strobe,
  output logic                             frame_error
);

  localparam int unsigned N     = BITS_PER_PAD * NUM_PADS;
  localparam int unsigned CNT_W = $clog2(N + 2);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  logic w_data_s;
  logic w_unused_data_rise;
  logic w_clk_level;
  logic w_clk_rise;
  logic w_latch_level;
  logic w_latch_rise;

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_data (
    .i_clk  (clk),
    .i_reset(reset),
    .i_async(pmod_data),
    .o_level(w_data_s),
    .o_rise (w_unused_data_rise)
  );

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_clk (
    .i_clk  (clk),
    .i_reset(reset),
    .i_async(pmod_clk),
    .o_level(w_clk_level),
    .o_rise (w_clk_rise)
  );

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_latch (
    .i_clk  (clk),
    .i_reset(reset),
    .i_async(pmod_latch),
    .o_level(w_latch_level),
    .o_rise (w_latch_rise)
  );

  logic [N-1:0]        r_shift;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic                r_close_ok;
  logic                r_close_bad;
  logic [N-1:0]        r_buttons;
  logic [NUM_PADS-1:0] r_present;
  logic                r_frame_strobe;
  logic                r_frame_error;
  logic [TO_W-1:0]     r_to_cnt;

  logic [N-1:0]        w_frame_buttons;
  logic [NUM_PADS-1:0] w_frame_present;
  logic                w_frame_len_ok;
  logic                w_to_expire;
  logic                w_unused_levels;

  assign w_frame_len_ok  = (r_bit_cnt == CNT_W'(N));
  assign w_to_expire     = (r_to_cnt >= TO_W'(TIMEOUT_CYCLES - 1));
  assign w_unused_levels = w_clk_level ^ w_latch_level;

  // Absent pads are masked to zero so downstream logic never sees phantom presses.
  always_comb begin
    w_frame_buttons = '0;
    w_frame_present = '0;
    for (int p = 0; p < NUM_PADS; p++) begin
      if (pad_present(r_shift[p*BITS_PER_PAD +: BITS_PER_PAD])) begin
        w_frame_present[p] = 1'b1;
        w_frame_buttons[p*BITS_PER_PAD +: BITS_PER_PAD] =
          r_shift[p*BITS_PER_PAD +: BITS_PER_PAD];
      end
    end
  end

  // Frame assembly; a latch edge takes priority over a coincident shift-clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_close_ok  <= 1'b0;
      r_close_bad <= 1'b0;
    end else begin
      r_close_ok  <= 1'b0;
      r_close_bad <= 1'b0;
      if (w_latch_rise) begin
        r_close_ok  <= w_frame_len_ok;
        r_close_bad <= ~w_frame_len_ok;
        r_bit_cnt   <= '0;
      end else if (w_clk_rise) begin
        r_shift <= {r_shift[N-2:0], w_data_s};
        if (r_bit_cnt != CNT_W'(N + 1)) begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end
    end
  end

  // Output update one cycle after frame close, plus the no-frame timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buttons      <= '0;
      r_present      <= '0;
      r_frame_strobe <= 1'b0;
      r_frame_error  <= 1'b0;
      r_to_cnt       <= '0;
    end else begin
      r_frame_strobe <= r_close_ok;
      r_frame_error  <= r_close_bad;
      if (r_close_ok) begin
        r_buttons <= w_frame_buttons;
        r_present <= w_frame_present;
        r_to_cnt  <= '0;
      end else begin
        if (r_to_cnt != TO_W'(TIMEOUT_CYCLES)) begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
        if (w_to_expire) begin
          r_buttons <= '0;
          r_present <= '0;
        end
      end
    end
  end

  assign buttons      = r_buttons;
  assign is_present   = r_present;
  assign frame_strobe = r_frame_strobe;
  assign frame_error  = r_frame_error;

endmodule

// File: tb/tb_gamepad_pmod_rx.sv
// Directed bench for gamepad_pmod_rx: valid/short/long frames, presence masking,
// timeout, clk/latch collision and mid-frame reset.
module tb_gamepad_pmod_rx;
  import gamepad_pmod_pkg::*;

  logic        clk;
  logic        reset;
  logic        pmod_data;
  logic        pmod_clk;
  logic        pmod_latch;
  logic [23:0] buttons;
  logic [1:0]  is_present;
  logic        frame_strobe;
  logic        frame_error;

  int n_vec = 0;
  int n_bad = 0;

  gamepad_pmod_rx #(
    .NUM_PADS      (2),
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pmod_data   (pmod_data),
    .pmod_clk    (pmod_clk),
    .pmod_latch  (pmod_latch),
    .buttons     (buttons),
    .is_present  (is_present),
    .frame_strobe(frame_strobe),
    .frame_error (frame_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Shifts the low n bits of word, most significant first; two clk cycles per bit.
  task automatic send_bits(input logic [31:0] word, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      pmod_data = word[i];
      pmod_clk  = 1'b1;
      @(negedge clk);
      pmod_clk  = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic pulse_latch(output int n_strobe, output int n_err);
    n_strobe   = 0;
    n_err      = 0;
    pmod_latch = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (frame_strobe) n_strobe++;
      if (frame_error) n_err++;
    end
    pmod_latch = 1'b0;
    @(negedge clk);
  endtask

  logic [23:0] exp_t1;
  int          ns;
  int          ne;
  int          found;

  initial begin
    exp_t1     = 24'(1 << (BITS_PER_PAD + BTN_B)) | 24'(1 << BTN_R);
    reset      = 1'b1;
    pmod_data  = 1'b0;
    pmod_clk   = 1'b0;
    pmod_latch = 1'b0;
    repeat (3) @(negedge clk);
    check("reset buttons", 32'(buttons), 32'h0);
    check("reset present", 32'(is_present), 32'h0);
    check("reset strobe", 32'(frame_strobe), 32'h0);
    check("reset error", 32'(frame_error), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // T1: valid frame with exact pin-to-output latency of SYNC_STAGES+2 cycles.
    send_bits(32'h800001, 24);
    pmod_latch = 1'b1;
    repeat (3) @(negedge clk);
    check("T1 latency hold buttons", 32'(buttons), 32'h0);
    check("T1 latency hold strobe", 32'(frame_strobe), 32'h0);
    @(negedge clk);
    check("T1 buttons", 32'(buttons), 32'(exp_t1));
    check("T1 present", 32'(is_present), 32'h3);
    check("T1 strobe", 32'(frame_strobe), 32'h1);
    check("T1 error", 32'(frame_error), 32'h0);
    @(negedge clk);
    check("T1 strobe one cycle", 32'(frame_strobe), 32'h0);
    pmod_latch = 1'b0;

    // T2: short then long frames close with an error and leave outputs alone.
    send_bits(32'h123456, 23);
    pulse_latch(ns, ne);
    check("T2 short error count", 32'(ne), 32'h1);
    check("T2 short strobe count", 32'(ns), 32'h0);
    check("T2 short buttons hold", 32'(buttons), 32'h800001);
    check("T2 short present hold", 32'(is_present), 32'h3);
    send_bits(32'h800001, 24);
    pulse_latch(ns, ne);
    check("T2 refresh strobe count", 32'(ns), 32'h1);
    send_bits(32'h1ABCDEF, 25);
    pulse_latch(ns, ne);
    check("T2 long error count", 32'(ne), 32'h1);
    check("T2 long strobe count", 32'(ns), 32'h0);
    check("T2 long buttons hold", 32'(buttons), 32'h800001);

    // T3: pad1 absent, pad0 present.
    send_bits(32'hFFF0F0, 24);
    pmod_latch = 1'b1;
    found      = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (frame_strobe) begin
        found = 1;
        break;
      end
    end
    check("T3 strobe seen", 32'(found), 32'h1);
    check("T3 buttons", 32'(buttons), 32'h0000F0);
    check("T3 present", 32'(is_present), 32'h1);
    check("T3 error", 32'(frame_error), 32'h0);
    pmod_latch = 1'b0;

    // T4: timeout lands exactly 64 cycles after the strobe.
    repeat (63) @(negedge clk);
    check("T4 before timeout present", 32'(is_present), 32'h1);
    check("T4 before timeout buttons", 32'(buttons), 32'h0000F0);
    @(negedge clk);
    check("T4 timeout buttons", 32'(buttons), 32'h0);
    check("T4 timeout present", 32'(is_present), 32'h0);
    check("T4 timeout no strobe", 32'(frame_strobe), 32'h0);
    send_bits(32'h0A53C0, 24);
    pulse_latch(ns, ne);
    check("T4 restore strobe count", 32'(ns), 32'h1);
    check("T4 restore buttons", 32'(buttons), 32'h0A53C0);
    check("T4 restore present", 32'(is_present), 32'h3);

    // T5: 25th clk edge coincides with latch; it must not be shifted.
    send_bits(32'h5A5A5A, 24);
    pmod_data  = 1'b1;
    pmod_clk   = 1'b1;
    pmod_latch = 1'b1;
    ns         = 0;
    ne         = 0;
    repeat (6) begin
      @(negedge clk);
      if (frame_strobe) ns++;
      if (frame_error) ne++;
    end
    pmod_clk   = 1'b0;
    pmod_latch = 1'b0;
    @(negedge clk);
    check("T5 strobe count", 32'(ns), 32'h1);
    check("T5 error count", 32'(ne), 32'h0);
    check("T5 buttons", 32'(buttons), 32'h5A5A5A);

    // T6: reset mid-frame discards the partial frame.
    send_bits(32'h3FF, 10);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("T6 reset buttons", 32'(buttons), 32'h0);
    check("T6 reset present", 32'(is_present), 32'h0);
    check("T6 reset strobe", 32'(frame_strobe), 32'h0);
    check("T6 reset error", 32'(frame_error), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    send_bits(32'h00C300, 24);
    pulse_latch(ns, ne);
    check("T6 strobe count", 32'(ns), 32'h1);
    check("T6 error count", 32'(ne), 32'h0);
    check("T6 buttons", 32'(buttons), 32'h00C300);
    check("T6 present", 32'(is_present), 32'h3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
